// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates RV32I conditional branches in EX, registers the outcome,
// flags mispredicts and trains a table of 2-bit saturating counters read by fetch.
module branch_resolve_unit #(
  parameter  int XLEN        = 32,
  parameter  int BHT_ENTRIES = 64,
  localparam int IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            predict_taken,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [2:0]      ex_f3,
  input  logic            ex_pred_taken,
  input  logic            flush,
  output logic            res_valid,
  output logic            res_taken,
  output logic            res_mispredict,
  output logic [XLEN-1:0] res_redirect,
  output logic            res_illegal
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  function automatic logic cond_taken(input logic [2:0] f3,
                                      input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
    logic r;
    case (f3)
      3'b000:  r = (a == b);
      3'b001:  r = (a != b);
      3'b100:  r = ($signed(a) <  $signed(b));
      3'b101:  r = ($signed(a) >= $signed(b));
      3'b110:  r = (a <  b);
      3'b111:  r = (a >= b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic              accept_s;
  logic              illegal_s;
  logic              taken_s;
  logic [XLEN-1:0]   target_s;
  logic [XLEN-1:0]   seq_s;

  logic              res_valid_d,      res_valid_q;
  logic              res_taken_d,      res_taken_q;
  logic              res_mispredict_d, res_mispredict_q;
  logic [XLEN-1:0]   res_redirect_d,   res_redirect_q;
  logic              res_illegal_d,    res_illegal_q;
  logic [IDX_W-1:0]  res_idx_d,        res_idx_q;

  logic [1:0]        bht_q [BHT_ENTRIES];
  logic              upd_en_s;
  logic [1:0]        ctr_cur_s;
  logic [1:0]        ctr_nxt_s;
  logic [IDX_W-1:0]  fetch_idx_s;

  // Resolve the op in EX; an unaccepted slot loads an all-zero result.
  always_comb begin
    accept_s  = ex_valid & ~flush;
    illegal_s = (ex_f3 == 3'b010) | (ex_f3 == 3'b011);
    taken_s   = cond_taken(ex_f3, ex_rs1, ex_rs2);
    target_s  = ex_pc + ex_imm;
    seq_s     = ex_pc + PC_STEP;
    if (accept_s) begin
      res_valid_d      = 1'b1;
      res_taken_d      = taken_s;
      res_mispredict_d = taken_s ^ ex_pred_taken;
      res_redirect_d   = taken_s ? target_s : seq_s;
      res_illegal_d    = illegal_s;
      res_idx_d        = ex_pc[IDX_W+1:2];
    end else begin
      res_valid_d      = 1'b0;
      res_taken_d      = 1'b0;
      res_mispredict_d = 1'b0;
      res_redirect_d   = '0;
      res_illegal_d    = 1'b0;
      res_idx_d        = '0;
    end
  end

  // Result stage register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q      <= 1'b0;
      res_taken_q      <= 1'b0;
      res_mispredict_q <= 1'b0;
      res_redirect_q   <= '0;
      res_illegal_q    <= 1'b0;
      res_idx_q        <= '0;
    end else begin
      res_valid_q      <= res_valid_d;
      res_taken_q      <= res_taken_d;
      res_mispredict_q <= res_mispredict_d;
      res_redirect_q   <= res_redirect_d;
      res_illegal_q    <= res_illegal_d;
      res_idx_q        <= res_idx_d;
    end
  end

  // Saturating counter step for the branch leaving the result stage.
  always_comb begin
    upd_en_s  = res_valid_q & ~res_illegal_q;
    ctr_cur_s = bht_q[res_idx_q];
    if (res_taken_q) begin
      if (ctr_cur_s == 2'b11) begin
        ctr_nxt_s = 2'b11;
      end else begin
        ctr_nxt_s = ctr_cur_s + 2'b01;
      end
    end else begin
      if (ctr_cur_s == 2'b00) begin
        ctr_nxt_s = 2'b00;
      end else begin
        ctr_nxt_s = ctr_cur_s - 2'b01;
      end
    end
  end

  // Predictor table; reset leaves every entry weakly not-taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (upd_en_s) begin
      bht_q[res_idx_q] <= ctr_nxt_s;
    end else begin
      bht_q[res_idx_q] <= bht_q[res_idx_q];
    end
  end

  // Lookup reads the stored value, so a same-cycle update is seen only next cycle.
  always_comb begin
    fetch_idx_s   = fetch_pc[IDX_W+1:2];
    predict_taken = bht_q[fetch_idx_s][1];
  end

  assign ex_ready       = 1'b1;
  assign res_valid      = res_valid_q;
  assign res_taken      = res_taken_q;
  assign res_mispredict = res_mispredict_q;
  assign res_redirect   = res_redirect_q;
  assign res_illegal    = res_illegal_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus randomized
// back-to-back traffic compared against a counter-array reference model.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        predict_taken;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc, ex_rs1, ex_rs2, ex_imm;
  logic [2:0]  ex_f3;
  logic        ex_pred_taken;
  logic        flush;
  logic        res_valid, res_taken, res_mispredict, res_illegal;
  logic [31:0] res_redirect;

  int total = 0;
  int bad   = 0;
  int cnt [64];

  branch_resolve_unit dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .predict_taken(predict_taken),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_imm(ex_imm), .ex_f3(ex_f3), .ex_pred_taken(ex_pred_taken),
    .flush(flush), .res_valid(res_valid), .res_taken(res_taken),
    .res_mispredict(res_mispredict), .res_redirect(res_redirect), .res_illegal(res_illegal)
  );

  always #5 clk = ~clk;

  // Reference: branch direction straight from the funct3 table.
  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return (pc >> 2) % 64;
  endfunction

  task automatic model_train(input logic [31:0] pc, input logic taken);
    int i;
    i = idx_of(pc);
    if (taken) cnt[i] = (cnt[i] == 3) ? 3 : cnt[i] + 1;
    else       cnt[i] = (cnt[i] == 0) ? 0 : cnt[i] - 1;
  endtask

  // Presents one op at the negedge; returns #1 after the capturing edge.
  task automatic drive(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [2:0] f3, input logic pred,
                       input logic fl);
    @(negedge clk);
    ex_valid = 1'b1; ex_pc = pc; ex_rs1 = a; ex_rs2 = b; ex_imm = imm;
    ex_f3 = f3; ex_pred_taken = pred; flush = fl; fetch_pc = pc;
    @(posedge clk);
    #1;
    ex_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; ex_valid = 1'b0; flush = 1'b0; ex_pc = '0; ex_rs1 = '0; ex_rs2 = '0;
    ex_imm = '0; ex_f3 = '0; ex_pred_taken = 1'b0; fetch_pc = '0;
    for (int i = 0; i < 64; i++) cnt[i] = 1;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({res_valid, res_taken, res_mispredict, res_illegal} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {res_valid, res_taken, res_mispredict, res_illegal}); end
    total++; if (res_redirect !== 32'h0) begin bad++; $display("FAIL reset_redirect got=%h exp=00000000", res_redirect); end
    total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ex_ready); end
    total++; if (predict_taken !== 1'b0) begin bad++; $display("FAIL reset_predict got=%b exp=0", predict_taken); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_eq_basic;
    drive(32'h100, 32'd5, 32'd5, 32'h20, 3'b000, 1'b0, 1'b0);
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL eq_valid got=%b exp=1", res_valid); end
    total++; if (res_taken !== 1'b1) begin bad++; $display("FAIL eq_taken got=%b exp=1", res_taken); end
    total++; if (res_mispredict !== 1'b1) begin bad++; $display("FAIL eq_mispredict got=%b exp=1", res_mispredict); end
    total++; if (res_redirect !== 32'h120) begin bad++; $display("FAIL eq_redirect got=%h exp=00000120", res_redirect); end
    model_train(32'h100, 1'b1);
    @(posedge clk); #1;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL eq_pulse got=%b exp=0", res_valid); end
  endtask

  task automatic test_signed_unsigned;
    drive(32'h200, 32'hFFFF_FFFF, 32'd1, 32'h8, 3'b100, 1'b0, 1'b0);
    total++; if (res_taken !== 1'b1) begin bad++; $display("FAIL blt_taken got=%b exp=1", res_taken); end
    total++; if (res_redirect !== 32'h208) begin bad++; $display("FAIL blt_redirect got=%h exp=00000208", res_redirect); end
    model_train(32'h200, 1'b1);
    drive(32'h200, 32'hFFFF_FFFF, 32'd1, 32'h8, 3'b110, 1'b1, 1'b0);
    total++; if (res_taken !== 1'b0) begin bad++; $display("FAIL bltu_taken got=%b exp=0", res_taken); end
    total++; if (res_mispredict !== 1'b1) begin bad++; $display("FAIL bltu_mispredict got=%b exp=1", res_mispredict); end
    total++; if (res_redirect !== 32'h204) begin bad++; $display("FAIL bltu_redirect got=%h exp=00000204", res_redirect); end
    model_train(32'h200, 1'b0);
  endtask

  task automatic test_counter_train;
    logic exp_pred;
    for (int k = 0; k < 6; k++) begin
      // four taken (beq equal), then two not-taken (bne equal)
      drive(32'h40, 32'd7, 32'd7, 32'h10, (k < 4) ? 3'b000 : 3'b001, 1'b0, 1'b0);
      exp_pred = (cnt[16] >= 2);
      total++; if (predict_taken !== exp_pred) begin bad++; $display("FAIL train_pre%0d got=%b exp=%b", k, predict_taken, exp_pred); end
      model_train(32'h40, k < 4);
      @(posedge clk); #1;
      exp_pred = (cnt[16] >= 2);
      total++; if (predict_taken !== exp_pred) begin bad++; $display("FAIL train_post%0d got=%b exp=%b", k, predict_taken, exp_pred); end
    end
    total++; if (cnt[16] != 1 || predict_taken !== 1'b0) begin bad++; $display("FAIL train_final got=%b exp=0", predict_taken); end
  endtask

  task automatic test_illegal;
    drive(32'h40, 32'd3, 32'd3, 32'h10, 3'b011, 1'b1, 1'b0);
    total++; if ({res_valid, res_illegal, res_taken, res_mispredict} !== 4'b1101) begin bad++; $display("FAIL illegal_flags got=%b exp=1101", {res_valid, res_illegal, res_taken, res_mispredict}); end
    total++; if (res_redirect !== 32'h44) begin bad++; $display("FAIL illegal_redirect got=%h exp=00000044", res_redirect); end
    // Counter must still be 01: a single taken moves it to 10.
    drive(32'h40, 32'd3, 32'd3, 32'h10, 3'b000, 1'b1, 1'b0);
    model_train(32'h40, 1'b1);
    @(posedge clk); #1;
    total++; if (predict_taken !== 1'b1) begin bad++; $display("FAIL illegal_noupd got=%b exp=1", predict_taken); end
  endtask

  task automatic test_flush;
    drive(32'h80, 32'd1, 32'd1, 32'h10, 3'b000, 1'b0, 1'b1);
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", res_valid); end
    @(posedge clk); #1;
    total++; if (predict_taken !== 1'b0) begin bad++; $display("FAIL flush_noupd got=%b exp=0", predict_taken); end
  endtask

  task automatic test_wrap;
    drive(32'hFFFF_FFF0, 32'd9, 32'd9, 32'h20, 3'b000, 1'b1, 1'b0);
    total++; if (res_redirect !== 32'h10) begin bad++; $display("FAIL wrap_target got=%h exp=00000010", res_redirect); end
    model_train(32'hFFFF_FFF0, 1'b1);
    drive(32'hFFFF_FFFC, 32'd9, 32'd9, 32'h20, 3'b001, 1'b0, 1'b0);
    total++; if (res_redirect !== 32'h0) begin bad++; $display("FAIL wrap_seq got=%h exp=00000000", res_redirect); end
    model_train(32'hFFFF_FFFC, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [31:0] pc, a, b, imm, exp_redir;
    logic [2:0]  f3;
    logic        pred, fl, exp_t, exp_ill, exp_pred;
    for (int n = 0; n < 300; n++) begin
      pc   = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 3) * 21) << 2);
      a    = $urandom;
      b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
      imm  = $urandom;
      f3   = 3'($urandom_range(0, 7));
      pred = 1'($urandom_range(0, 1));
      fl   = ($urandom_range(0, 5) == 0);
      drive(pc, a, b, imm, f3, pred, fl);
      exp_t     = ref_taken(f3, a, b);
      exp_ill   = (f3 == 3'd2) || (f3 == 3'd3);
      exp_redir = exp_t ? pc + imm : pc + 32'd4;
      exp_pred  = (cnt[idx_of(pc)] >= 2);
      total++; if (predict_taken !== exp_pred) begin bad++; $display("FAIL b2b_predict n=%0d got=%b exp=%b", n, predict_taken, exp_pred); end
      total++; if (res_valid !== !fl) begin bad++; $display("FAIL b2b_valid n=%0d got=%b exp=%b", n, res_valid, !fl); end
      if (!fl) begin
        total++;
        if ({res_taken, res_mispredict, res_illegal} !== {exp_t, exp_t ^ pred, exp_ill} || res_redirect !== exp_redir) begin
          bad++;
          $display("FAIL b2b_result n=%0d got=%b/%h exp=%b/%h", n, {res_taken, res_mispredict, res_illegal}, res_redirect, {exp_t, exp_t ^ pred, exp_ill}, exp_redir);
        end
        if (!exp_ill) model_train(pc, exp_t);
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) begin
      fetch_pc = 32'(i) << 2;
      #1;
      total++; if (predict_taken !== (cnt[i] >= 2)) begin bad++; $display("FAIL b2b_table idx=%0d got=%b exp=%b", i, predict_taken, cnt[i] >= 2); end
    end
  endtask

  task automatic test_reset_mid;
    drive(32'h40, 32'd2, 32'd2, 32'h10, 3'b000, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    total++; if ({res_valid, res_taken, res_mispredict, res_illegal} !== 4'b0000 || res_redirect !== 32'h0) begin bad++; $display("FAIL rstmid_res got=%b/%h exp=0000/00000000", {res_valid, res_taken, res_mispredict, res_illegal}, res_redirect); end
    for (int i = 0; i < 64; i++) cnt[i] = 1;
    for (int i = 0; i < 64; i++) begin
      fetch_pc = 32'(i) << 2;
      #1;
      total++; if (predict_taken !== 1'b0) begin bad++; $display("FAIL rstmid_table idx=%0d got=%b exp=0", i, predict_taken); end
    end
    @(negedge clk);
    rst = 1'b0;
    // A single taken after reset must flip prediction (counter was 01).
    for (int j = 0; j < 2; j++) begin
      drive(32'h40 + 32'(j) * 32'h44, 32'd2, 32'd2, 32'h10, 3'b000, 1'b0, 1'b0);
      @(posedge clk); #1;
      total++; if (predict_taken !== 1'b1) begin bad++; $display("FAIL rstmid_weak j=%0d got=%b exp=1", j, predict_taken); end
    end
  endtask

  initial begin
    test_reset();
    test_eq_basic();
    test_signed_unsigned();
    test_counter_train();
    test_illegal();
    test_flush();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
